// File: rtl/ioctl_dispatch_pkg.sv
// Shared types for the ioctl ROM dispatcher: FSM states, region descriptors
// and the helper that slices one region out of the packed base/size vectors.
package ioctl_dispatch_pkg;

  localparam int IOCTL_ADDR_W = 27;
  localparam int MAX_REGIONS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic [IOCTL_ADDR_W-1:0] base;
    logic [IOCTL_ADDR_W-1:0] size;
  } region_t;

  function automatic region_t region_at(
    input logic [MAX_REGIONS*IOCTL_ADDR_W-1:0] bases,
    input logic [MAX_REGIONS*IOCTL_ADDR_W-1:0] sizes,
    input int                                  idx
  );
    region_t r;
    r.base = bases[idx*IOCTL_ADDR_W +: IOCTL_ADDR_W];
    r.size = sizes[idx*IOCTL_ADDR_W +: IOCTL_ADDR_W];
    return r;
  endfunction

endpackage

// File: rtl/ioctl_region_decode.sv
// Combinational byte-address decode: first region whose [base, base+size)
// window contains the address wins; returns one-hot region and byte offset.
module ioctl_region_decode
  import ioctl_dispatch_pkg::*;
#(
  parameter int                                  NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*IOCTL_ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*IOCTL_ADDR_W-1:0] REGION_SIZE = '0
) (
  input  logic [IOCTL_ADDR_W-1:0] addr,
  output logic                    hit,
  output logic [NUM_REGIONS-1:0]  region_oh,
  output logic [IOCTL_ADDR_W-1:0] offset
);

  localparam int PW = MAX_REGIONS * IOCTL_ADDR_W;
  localparam logic [PW-1:0] BASES = PW'(REGION_BASE);
  localparam logic [PW-1:0] SIZES = PW'(REGION_SIZE);

  region_t                 rg;
  logic [IOCTL_ADDR_W:0]   lim;

  // Limit is computed one bit wider so a region ending at the top of the
  // 27-bit space does not wrap to zero.
  always_comb begin
    hit       = 1'b0;
    region_oh = '0;
    offset    = '0;
    rg        = '0;
    lim       = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      rg  = region_at(BASES, SIZES, r);
      lim = {1'b0, rg.base} + {1'b0, rg.size};
      if (!hit && (addr >= rg.base) && ({1'b0, addr} < lim)) begin
        hit          = 1'b1;
        region_oh[r] = 1'b1;
        offset       = addr - rg.base;
      end
    end
  end

endmodule

// File: rtl/ioctl_rom_dispatcher.sv
// Routes the hps_io download byte stream into NUM_REGIONS ROM write ports,
// packing bytes into DATA_W words, and captures DIP-switch downloads.
//
// state | meaning
// IDLE  | no ROM download active
// FILL  | collecting bytes into the word buffer
// ISSUE | word presented on o_WR_*, hps_io held off until ack
// FLUSH | trailing partial word presented after download end
// DONE  | one-cycle completion pulse
module ioctl_rom_dispatcher
  import ioctl_dispatch_pkg::*;
#(
  parameter int                                  NUM_REGIONS = 4,
  parameter int                                  DATA_W      = 16,
  parameter int                                  ADDR_W      = 24,
  parameter logic [NUM_REGIONS*IOCTL_ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*IOCTL_ADDR_W-1:0] REGION_SIZE = '0,
  parameter logic [15:0]                         ROM_INDEX   = 16'd0,
  parameter logic [15:0]                         DIP_INDEX   = 16'd254,
  parameter logic [63:0]                         DIP_DEFAULT = 64'h0
) (
  input  logic                    i_EMU_MCLK,
  input  logic                    i_EMU_RST_n,
  input  logic [15:0]             i_IOCTL_INDEX,
  input  logic                    i_IOCTL_DOWNLOAD,
  input  logic [IOCTL_ADDR_W-1:0] i_IOCTL_ADDR,
  input  logic [7:0]              i_IOCTL_DATA,
  input  logic                    i_IOCTL_WR,
  output logic                    o_IOCTL_WAIT,
  output logic [NUM_REGIONS-1:0]  o_WR_REQ,
  input  logic [NUM_REGIONS-1:0]  i_WR_ACK,
  output logic [ADDR_W-1:0]       o_WR_ADDR,
  output logic [DATA_W-1:0]       o_WR_DATA,
  output logic [63:0]             o_DIPSW,
  output logic                    o_LOADING,
  output logic                    o_DONE,
  output logic                    o_ERR
);

  localparam int                      B         = DATA_W / 8;
  localparam int                      LANE_W    = (B > 1) ? $clog2(B) : 1;
  localparam logic [IOCTL_ADDR_W-1:0] B_DIV     = IOCTL_ADDR_W'(B);
  localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(B - 1);
  localparam logic [DATA_W-1:0]       ALL_FF    = '1;

  state_t                   state_q, state_nxt;
  logic                     dl_prev_q;
  logic [DATA_W-1:0]        buf_q, buf_nxt;
  logic                     buf_vld_q, buf_vld_nxt;
  logic                     buf_full_q, buf_full_nxt;
  logic [NUM_REGIONS-1:0]   cur_oh_q, cur_oh_nxt;
  logic [ADDR_W-1:0]        cur_waddr_q, cur_waddr_nxt;
  logic                     pend_vld_q, pend_vld_nxt;
  logic [7:0]               pend_data_q, pend_data_nxt;
  logic [LANE_W-1:0]        pend_lane_q, pend_lane_nxt;
  logic [NUM_REGIONS-1:0]   pend_oh_q, pend_oh_nxt;
  logic [ADDR_W-1:0]        pend_waddr_q, pend_waddr_nxt;
  logic [NUM_REGIONS-1:0]   req_oh_q, req_oh_nxt;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_nxt;
  logic [DATA_W-1:0]        wr_data_q, wr_data_nxt;
  logic                     err_q, err_nxt;
  logic [63:0]              dipsw_q, dipsw_nxt;

  logic                     dec_hit;
  logic [NUM_REGIONS-1:0]   dec_oh;
  logic [IOCTL_ADDR_W-1:0]  dec_off;
  logic [LANE_W-1:0]        dec_lane;
  logic [ADDR_W-1:0]        dec_waddr;

  logic                     rom_sel, dip_sel, waiting;
  logic                     launch;
  logic [DATA_W-1:0]        launch_data;
  logic [NUM_REGIONS-1:0]   launch_oh;
  logic [ADDR_W-1:0]        launch_addr;
  logic [DATA_W-1:0]        image;

  ioctl_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .addr      (i_IOCTL_ADDR),
    .hit       (dec_hit),
    .region_oh (dec_oh),
    .offset    (dec_off)
  );

  assign dec_lane  = LANE_W'(dec_off % B_DIV);
  assign dec_waddr = ADDR_W'(dec_off / B_DIV);

  assign rom_sel = (i_IOCTL_INDEX == ROM_INDEX);
  assign dip_sel = (i_IOCTL_INDEX == DIP_INDEX);
  assign waiting = (state_q == ISSUE) || (state_q == FLUSH);

  assign o_IOCTL_WAIT = waiting;
  assign o_WR_REQ     = waiting ? req_oh_q : '0;
  assign o_WR_ADDR    = wr_addr_q;
  assign o_WR_DATA    = wr_data_q;
  assign o_DIPSW      = dipsw_q;
  assign o_LOADING    = (state_q == FILL) || waiting;
  assign o_DONE       = (state_q == DONE);
  assign o_ERR        = err_q;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      state_q      <= IDLE;
      dl_prev_q    <= 1'b0;
      buf_q        <= ALL_FF;
      buf_vld_q    <= 1'b0;
      buf_full_q   <= 1'b0;
      cur_oh_q     <= '0;
      cur_waddr_q  <= '0;
      pend_vld_q   <= 1'b0;
      pend_data_q  <= '0;
      pend_lane_q  <= '0;
      pend_oh_q    <= '0;
      pend_waddr_q <= '0;
      req_oh_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
      dipsw_q      <= DIP_DEFAULT;
    end else begin
      state_q      <= state_nxt;
      dl_prev_q    <= i_IOCTL_DOWNLOAD;
      buf_q        <= buf_nxt;
      buf_vld_q    <= buf_vld_nxt;
      buf_full_q   <= buf_full_nxt;
      cur_oh_q     <= cur_oh_nxt;
      cur_waddr_q  <= cur_waddr_nxt;
      pend_vld_q   <= pend_vld_nxt;
      pend_data_q  <= pend_data_nxt;
      pend_lane_q  <= pend_lane_nxt;
      pend_oh_q    <= pend_oh_nxt;
      pend_waddr_q <= pend_waddr_nxt;
      req_oh_q     <= req_oh_nxt;
      wr_addr_q    <= wr_addr_nxt;
      wr_data_q    <= wr_data_nxt;
      err_q        <= err_nxt;
      dipsw_q      <= dipsw_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    buf_nxt        = buf_q;
    buf_vld_nxt    = buf_vld_q;
    buf_full_nxt   = buf_full_q;
    cur_oh_nxt     = cur_oh_q;
    cur_waddr_nxt  = cur_waddr_q;
    pend_vld_nxt   = pend_vld_q;
    pend_data_nxt  = pend_data_q;
    pend_lane_nxt  = pend_lane_q;
    pend_oh_nxt    = pend_oh_q;
    pend_waddr_nxt = pend_waddr_q;
    req_oh_nxt     = req_oh_q;
    wr_addr_nxt    = wr_addr_q;
    wr_data_nxt    = wr_data_q;
    err_nxt        = err_q;
    dipsw_nxt      = dipsw_q;
    launch         = 1'b0;
    launch_data    = buf_q;
    launch_oh      = cur_oh_q;
    launch_addr    = cur_waddr_q;
    image          = buf_q;

    // DIP capture runs beside the ROM path and never stalls hps_io.
    if (i_IOCTL_WR && dip_sel && (i_IOCTL_ADDR < IOCTL_ADDR_W'(8)))
      dipsw_nxt[8*int'(i_IOCTL_ADDR[2:0]) +: 8] = i_IOCTL_DATA;

    if (i_IOCTL_WR && rom_sel && waiting)
      err_nxt = 1'b1;

    case (state_q)
      IDLE: begin
        if (rom_sel && i_IOCTL_DOWNLOAD && !dl_prev_q) begin
          state_nxt    = FILL;
          err_nxt      = 1'b0;
          buf_nxt      = ALL_FF;
          buf_vld_nxt  = 1'b0;
          buf_full_nxt = 1'b0;
          pend_vld_nxt = 1'b0;
        end
      end

      FILL: begin
        if (!i_IOCTL_DOWNLOAD) begin
          if (buf_vld_q) begin
            launch    = 1'b1;
            state_nxt = FLUSH;
          end else begin
            state_nxt = DONE;
          end
        end else if (i_IOCTL_WR && rom_sel) begin
          if (!dec_hit) begin
            err_nxt = 1'b1;
          end else if (buf_vld_q && (buf_full_q || (dec_oh != cur_oh_q) ||
                                     (dec_waddr != cur_waddr_q))) begin
            // Buffered word belongs elsewhere: send it, park the new byte.
            launch         = 1'b1;
            state_nxt      = ISSUE;
            pend_vld_nxt   = 1'b1;
            pend_data_nxt  = i_IOCTL_DATA;
            pend_lane_nxt  = dec_lane;
            pend_oh_nxt    = dec_oh;
            pend_waddr_nxt = dec_waddr;
          end else begin
            image[8*int'(dec_lane) +: 8] = i_IOCTL_DATA;
            if (dec_lane == LAST_LANE) begin
              launch      = 1'b1;
              launch_data = image;
              launch_oh   = dec_oh;
              launch_addr = dec_waddr;
              state_nxt   = ISSUE;
            end else begin
              buf_nxt       = image;
              buf_vld_nxt   = 1'b1;
              cur_oh_nxt    = dec_oh;
              cur_waddr_nxt = dec_waddr;
            end
          end
        end else if (buf_full_q) begin
          launch    = 1'b1;
          state_nxt = ISSUE;
        end
      end

      ISSUE, FLUSH: begin
        if (|(i_WR_ACK & req_oh_q)) begin
          if (state_q == FLUSH) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FILL;
            if (pend_vld_q) begin
              image                           = ALL_FF;
              image[8*int'(pend_lane_q) +: 8] = pend_data_q;
              buf_nxt       = image;
              buf_vld_nxt   = 1'b1;
              buf_full_nxt  = (pend_lane_q == LAST_LANE);
              cur_oh_nxt    = pend_oh_q;
              cur_waddr_nxt = pend_waddr_q;
              pend_vld_nxt  = 1'b0;
            end
          end
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase

    if (launch) begin
      wr_data_nxt  = launch_data;
      wr_addr_nxt  = launch_addr;
      req_oh_nxt   = launch_oh;
      buf_nxt      = ALL_FF;
      buf_vld_nxt  = 1'b0;
      buf_full_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_ioctl_rom_dispatcher.sv
// Directed bench for ioctl_rom_dispatcher: two 256-byte regions, 16-bit words,
// scoreboard of expected target writes checked as each request is served.
module tb_ioctl_rom_dispatcher;

  localparam int NR = 2;

  logic          clk;
  logic          rst_n;
  logic [15:0]   ioctl_index;
  logic          ioctl_download;
  logic [26:0]   ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          ioctl_wait;
  logic [NR-1:0] wr_req;
  logic [NR-1:0] wr_ack;
  logic [23:0]   wr_addr;
  logic [15:0]   wr_data;
  logic [63:0]   dipsw;
  logic          loading;
  logic          done;
  logic          err;

  typedef struct {
    logic [NR-1:0] req;
    logic [23:0]   addr;
    logic [15:0]   data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ioctl_rom_dispatcher #(
    .NUM_REGIONS (NR),
    .DATA_W      (16),
    .ADDR_W      (24),
    .REGION_BASE ({27'h100, 27'h000}),
    .REGION_SIZE ({27'h100, 27'h100}),
    .ROM_INDEX   (16'd0),
    .DIP_INDEX   (16'd254),
    .DIP_DEFAULT (64'h0)
  ) dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_RST_n      (rst_n),
    .i_IOCTL_INDEX    (ioctl_index),
    .i_IOCTL_DOWNLOAD (ioctl_download),
    .i_IOCTL_ADDR     (ioctl_addr),
    .i_IOCTL_DATA     (ioctl_data),
    .i_IOCTL_WR       (ioctl_wr),
    .o_IOCTL_WAIT     (ioctl_wait),
    .o_WR_REQ         (wr_req),
    .i_WR_ACK         (wr_ack),
    .o_WR_ADDR        (wr_addr),
    .o_WR_DATA        (wr_data),
    .o_DIPSW          (dipsw),
    .o_LOADING        (loading),
    .o_DONE           (done),
    .o_ERR            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(posedge clk);
    #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic push_exp(input logic [NR-1:0] r, input logic [23:0] a, input logic [15:0] d);
    exp_t e;
    e.req  = r;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for a request, compare against the scoreboard head, hold
  // it for 'delay' cycles with acks on the other regions, then ack it.
  task automatic serve(input int delay, input int exp_lat, input string tag);
    int            n;
    exp_t          e;
    logic [NR-1:0] req;
    n = 0;
    while (wr_req == '0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    e.req  = 'x;
    e.addr = 'x;
    e.data = 'x;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check({tag, "_req"},  64'(wr_req),     64'(e.req));
    check({tag, "_addr"}, 64'(wr_addr),    64'(e.addr));
    check({tag, "_data"}, 64'(wr_data),    64'(e.data));
    check({tag, "_wait"}, 64'(ioctl_wait), 64'd1);
    req = wr_req;
    for (int i = 0; i < delay; i++) begin
      wr_ack = ~req;
      @(posedge clk);
      #1;
      check({tag, "_held"}, {31'd0, ioctl_wait, 14'd0, wr_req, wr_data}, {31'd0, 1'b1, 14'd0, req, e.data});
    end
    wr_ack = req;
    @(posedge clk);
    #1;
    wr_ack = '0;
    check({tag, "_req_drop"},  64'(wr_req),     64'd0);
    check({tag, "_wait_drop"}, 64'(ioctl_wait), 64'd0);
  endtask

  initial begin
    logic seen;
    rst_n          = 1'b0;
    ioctl_index    = 16'd0;
    ioctl_download = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    ioctl_wr       = 1'b0;
    wr_ack         = '0;
    tick(3);
    check("rst_wait",    64'(ioctl_wait), 64'd0);
    check("rst_req",     64'(wr_req),     64'd0);
    check("rst_addr",    64'(wr_addr),    64'd0);
    check("rst_data",    64'(wr_data),    64'd0);
    check("rst_loading", 64'(loading),    64'd0);
    check("rst_done",    64'(done),       64'd0);
    check("rst_err",     64'(err),        64'd0);
    check("rst_dipsw",   dipsw,           64'h0);
    rst_n = 1'b1;
    tick(1);

    // Download A: four bytes, two full words, slow then immediate ack.
    ioctl_index    = 16'd0;
    ioctl_download = 1'b1;
    tick(1);
    check("a_loading", 64'(loading), 64'd1);
    wr_byte(27'h0, 8'h00);
    push_exp(2'b01, 24'h0, 16'h0100);
    wr_byte(27'h1, 8'h01);
    serve(3, 0, "a_w0");
    wr_byte(27'h2, 8'h02);
    push_exp(2'b01, 24'h1, 16'h0302);
    wr_byte(27'h3, 8'h03);
    serve(0, 0, "a_w1");
    ioctl_download = 1'b0;
    tick(1);
    check("a_done",         64'(done),    64'd1);
    check("a_loading_done", 64'(loading), 64'd0);
    tick(1);
    check("a_done_pulse",   64'(done),    64'd0);

    // Download B: odd length, trailing byte flushed with 0xFF fill.
    ioctl_download = 1'b1;
    tick(1);
    wr_byte(27'h0, 8'h00);
    push_exp(2'b01, 24'h0, 16'h0100);
    wr_byte(27'h1, 8'h01);
    serve(0, 0, "b_w0");
    wr_byte(27'h2, 8'h02);
    check("b_no_req_partial", 64'(wr_req), 64'd0);
    push_exp(2'b01, 24'h1, 16'hFF02);
    ioctl_download = 1'b0;
    serve(1, 1, "b_flush");
    check("b_done",       64'(done), 64'd1);
    tick(1);
    check("b_done_pulse", 64'(done), 64'd0);

    // Download C: region crossing with partial word, then write during wait.
    ioctl_download = 1'b1;
    tick(1);
    wr_byte(27'h0FE, 8'hAA);
    push_exp(2'b01, 24'h7F, 16'hFFAA);
    wr_byte(27'h100, 8'hBB);
    serve(1, 0, "c_cross");
    push_exp(2'b10, 24'h0, 16'hCCBB);
    wr_byte(27'h101, 8'hCC);
    wr_byte(27'h102, 8'h55);
    serve(2, 0, "c_r1w0");
    check("c_err_wait_wr", 64'(err), 64'd1);
    ioctl_download = 1'b0;
    tick(1);
    check("c_done", 64'(done), 64'd1);
    tick(1);

    // Download D: error clear on start, out-of-range byte, then reset mid-issue.
    ioctl_download = 1'b1;
    tick(1);
    check("d_err_cleared", 64'(err), 64'd0);
    wr_byte(27'h300, 8'h99);
    check("d_err_range", 64'(err), 64'd1);
    check("d_range_req", {62'd0, ioctl_wait, |wr_req}, 64'd0);
    wr_byte(27'h1FE, 8'h44);
    push_exp(2'b10, 24'h7F, 16'h4544);
    wr_byte(27'h1FF, 8'h45);
    serve(2, 0, "d_r1last");
    wr_byte(27'h10, 8'h46);
    wr_byte(27'h11, 8'h47);
    check("d_issue_req",  64'(wr_req),  64'h1);
    check("d_issue_data", 64'(wr_data), 64'h4746);
    #3;
    rst_n = 1'b0;
    #1;
    check("d_rst_req",     64'(wr_req),     64'd0);
    check("d_rst_wait",    64'(ioctl_wait), 64'd0);
    check("d_rst_loading", 64'(loading),    64'd0);
    ioctl_download = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen = seen | done | loading | (|wr_req);
    end
    check("d_no_done_after_rst", 64'(seen), 64'd0);

    // DIP download: bytes land in the register, no stall, no ROM activity.
    ioctl_index    = 16'd254;
    ioctl_download = 1'b1;
    tick(1);
    wr_byte(27'h0, 8'hA5);
    check("dip_byte0", dipsw, 64'h0000_0000_0000_00A5);
    seen = ioctl_wait | loading;
    wr_byte(27'h7, 8'h3C);
    seen = seen | ioctl_wait | loading;
    wr_byte(27'h8, 8'h11);
    seen = seen | ioctl_wait | loading;
    tick(1);
    check("dip_value",    dipsw,      64'h3C00_0000_0000_00A5);
    check("dip_no_stall", 64'(seen),  64'd0);
    check("dip_no_err",   64'(err),   64'd0);
    ioctl_download = 1'b0;
    tick(1);

    // Unrelated index: stream ignored entirely.
    ioctl_index    = 16'd5;
    ioctl_download = 1'b1;
    tick(1);
    wr_byte(27'h0, 8'h77);
    tick(1);
    check("other_quiet", {dipsw[7:0], 5'd0, loading, |wr_req, err}, {8'hA5, 8'h00});
    ioctl_download = 1'b0;
    tick(1);

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
